// File: rtl/hazard_unit_if.sv
// Port bundle between the ID stage and the hazard unit: instruction descriptors
// in, stall/flush/forward controls and event counters out.
interface hazard_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  branch_taken;
  logic                  stall;
  logic                  flush_if_id;
  logic                  flush_id_ex;
  logic                  flush_ex_mem;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_reg_write, id_mem_read, id_rd, branch_taken,
    input  stall, flush_if_id, flush_id_ex, flush_ex_mem,
           fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_reg_write, id_mem_read, id_rd, branch_taken,
    output stall, flush_if_id, flush_id_ex, flush_ex_mem,
           fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Five-stage MIPS hazard unit: EX/MEM destination scoreboard, stall/flush
// generation, registered forwarding selects and saturating event counters.
module hazard_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter bit FWD_EN       = 1'b1,
  parameter bit BRANCH_IN_EX = 1'b0,
  parameter int CNT_W        = 16
) (
  input  logic         clk,
  input  logic         reset,
  hazard_unit_if.slave hz
);

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_read;
    logic [REG_ADDR_W-1:0] rd;
  } slot_t;

  typedef enum logic [1:0] {
    SEL_RF     = 2'd0,
    SEL_EX_MEM = 2'd1,
    SEL_MEM_WB = 2'd2
  } fwd_sel_e;

  slot_t            ex_q, mem_q, id_slot;
  fwd_sel_e         fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             ex_a, ex_b, mem_a, mem_b;
  logic             hazard, stall, advance;

  // Register 0 is hardwired zero, so a write to it never creates a dependence.
  function automatic logic slot_match(slot_t s, logic [REG_ADDR_W-1:0] src, logic uses);
    return s.valid && s.reg_write && (s.rd != '0) && (s.rd == src) && uses;
  endfunction

  assign ex_a    = slot_match(ex_q,  hz.id_rs, hz.id_uses_rs);
  assign ex_b    = slot_match(ex_q,  hz.id_rt, hz.id_uses_rt);
  assign mem_a   = slot_match(mem_q, hz.id_rs, hz.id_uses_rs);
  assign mem_b   = slot_match(mem_q, hz.id_rt, hz.id_uses_rt);
  assign id_slot = {hz.id_valid, hz.id_reg_write, hz.id_mem_read, hz.id_rd};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hazard  = 1'b0;
    fwd_a_d = SEL_RF;
    fwd_b_d = SEL_RF;
    if (hz.id_valid) begin
      if (FWD_EN) hazard = ex_q.mem_read && (ex_a || ex_b);
      else        hazard = ex_a || ex_b || mem_a || mem_b;
    end
    stall   = hazard && !hz.branch_taken && !reset;
    advance = !reset && !hz.branch_taken && !stall;
    // The EX slot holds the youngest producer, so its result wins over MEM's.
    if (FWD_EN && advance) begin
      if (ex_a)       fwd_a_d = SEL_EX_MEM;
      else if (mem_a) fwd_a_d = SEL_MEM_WB;
      if (ex_b)       fwd_b_d = SEL_EX_MEM;
      else if (mem_b) fwd_b_d = SEL_MEM_WB;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q    <= '0;
      mem_q   <= '0;
      fwd_a_q <= SEL_RF;
      fwd_b_q <= SEL_RF;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      if (hz.branch_taken) begin
        ex_q  <= '0;
        mem_q <= BRANCH_IN_EX ? ex_q : '0;
      end else if (stall) begin
        ex_q  <= '0;
        mem_q <= ex_q;
      end else begin
        ex_q  <= id_slot;
        mem_q <= ex_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (hz.branch_taken && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign hz.stall        = stall;
  assign hz.flush_if_id  = hz.branch_taken && !reset;
  assign hz.flush_id_ex  = hz.branch_taken && !reset;
  assign hz.flush_ex_mem = hz.branch_taken && !BRANCH_IN_EX && !reset;
  assign hz.fwd_a_sel    = fwd_a_q;
  assign hz.fwd_b_sel    = fwd_b_q;
  assign hz.stall_cnt    = stall_cnt_q;
  assign hz.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two configurations (forwarding/branch-in-MEM/16-bit counters
// and stall-only/branch-in-EX/2-bit counters) driven in lockstep against a pipeline model.
module tb_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, branch_taken;
  logic [4:0] id_rs, id_rt, id_rd;

  hazard_unit_if #(.REG_ADDR_W(5), .CNT_W(16)) if0 ();
  hazard_unit_if #(.REG_ADDR_W(5), .CNT_W(2))  if1 ();

  assign if0.id_valid = id_valid;         assign if1.id_valid = id_valid;
  assign if0.id_rs = id_rs;               assign if1.id_rs = id_rs;
  assign if0.id_rt = id_rt;               assign if1.id_rt = id_rt;
  assign if0.id_uses_rs = id_uses_rs;     assign if1.id_uses_rs = id_uses_rs;
  assign if0.id_uses_rt = id_uses_rt;     assign if1.id_uses_rt = id_uses_rt;
  assign if0.id_reg_write = id_reg_write; assign if1.id_reg_write = id_reg_write;
  assign if0.id_mem_read = id_mem_read;   assign if1.id_mem_read = id_mem_read;
  assign if0.id_rd = id_rd;               assign if1.id_rd = id_rd;
  assign if0.branch_taken = branch_taken; assign if1.branch_taken = branch_taken;

  hazard_unit #(.REG_ADDR_W(5), .FWD_EN(1'b1), .BRANCH_IN_EX(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .hz(if0)
  );
  hazard_unit #(.REG_ADDR_W(5), .FWD_EN(1'b0), .BRANCH_IN_EX(1'b1), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .hz(if1)
  );

  logic        o_stall [2];
  logic [2:0]  o_flush [2];
  logic [1:0]  o_sel_a [2];
  logic [1:0]  o_sel_b [2];
  logic [31:0] o_scnt  [2];
  logic [31:0] o_fcnt  [2];

  assign o_stall[0] = if0.stall;
  assign o_stall[1] = if1.stall;
  assign o_flush[0] = {if0.flush_if_id, if0.flush_id_ex, if0.flush_ex_mem};
  assign o_flush[1] = {if1.flush_if_id, if1.flush_id_ex, if1.flush_ex_mem};
  assign o_sel_a[0] = if0.fwd_a_sel;
  assign o_sel_a[1] = if1.fwd_a_sel;
  assign o_sel_b[0] = if0.fwd_b_sel;
  assign o_sel_b[1] = if1.fwd_b_sel;
  assign o_scnt[0]  = 32'(if0.stall_cnt);
  assign o_scnt[1]  = 32'(if1.stall_cnt);
  assign o_fcnt[0]  = 32'(if0.flush_cnt);
  assign o_fcnt[1]  = 32'(if1.flush_cnt);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Pipeline model: the in-flight instruction sitting in EX and in MEM per configuration.
  typedef struct packed {
    bit       valid;
    bit       wr;
    bit       ld;
    bit [4:0] rd;
  } instr_t;

  instr_t m_ex [2];
  instr_t m_mem[2];
  int     m_sel_a[2], m_sel_b[2], m_scnt[2], m_fcnt[2];
  logic   last_stall[2];
  logic [2:0] last_flush[2];

  function automatic bit cfg_fwd(int k); return k == 0; endfunction
  function automatic bit cfg_bie(int k); return k == 1; endfunction
  function automatic int cfg_max(int k); return (k == 0) ? 65535 : 3; endfunction

  function automatic bit feeds(instr_t p, int src, bit uses);
    return uses && p.valid && p.wr && (p.rd != 0) && (int'(p.rd) == src);
  endfunction

  function automatic bit exp_stall(int k);
    bit from_ex, from_mem;
    if (reset || branch_taken || !id_valid) return 1'b0;
    from_ex  = feeds(m_ex[k],  int'(id_rs), id_uses_rs) || feeds(m_ex[k],  int'(id_rt), id_uses_rt);
    from_mem = feeds(m_mem[k], int'(id_rs), id_uses_rs) || feeds(m_mem[k], int'(id_rt), id_uses_rt);
    if (cfg_fwd(k)) return from_ex && m_ex[k].ld;
    return from_ex || from_mem;
  endfunction

  function automatic int pick_src(int k, int src, bit uses);
    if (feeds(m_ex[k], src, uses))  return 1;
    if (feeds(m_mem[k], src, uses)) return 2;
    return 0;
  endfunction

  task automatic model_update(input int k);
    bit     st;
    int     sa, sb;
    instr_t nw;
    st = exp_stall(k);
    sa = 0;
    sb = 0;
    if (reset) begin
      m_ex[k] = '0; m_mem[k] = '0;
      m_sel_a[k] = 0; m_sel_b[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
      return;
    end
    if (st && m_scnt[k] < cfg_max(k)) m_scnt[k]++;
    if (branch_taken && m_fcnt[k] < cfg_max(k)) m_fcnt[k]++;
    if (branch_taken) begin
      m_mem[k] = cfg_bie(k) ? m_ex[k] : '0;
      m_ex[k]  = '0;
    end else if (st) begin
      m_mem[k] = m_ex[k];
      m_ex[k]  = '0;
    end else begin
      if (cfg_fwd(k)) begin
        sa = pick_src(k, int'(id_rs), id_uses_rs);
        sb = pick_src(k, int'(id_rt), id_uses_rt);
      end
      nw.valid = id_valid; nw.wr = id_reg_write; nw.ld = id_mem_read; nw.rd = id_rd;
      m_mem[k] = m_ex[k];
      m_ex[k]  = nw;
    end
    m_sel_a[k] = sa;
    m_sel_b[k] = sb;
  endtask

  // One pipeline cycle: drive at negedge, compare all outputs, advance the model at posedge.
  task automatic step(input bit rst, input bit v, input int rs, input bit urs,
                      input int rt, input bit urt, input bit wr, input bit ld,
                      input int rd, input bit br);
    logic [2:0] ef;
    @(negedge clk);
    reset = rst; id_valid = v; id_rs = 5'(rs); id_uses_rs = urs;
    id_rt = 5'(rt); id_uses_rt = urt; id_reg_write = wr; id_mem_read = ld;
    id_rd = 5'(rd); branch_taken = br;
    #1;
    for (int k = 0; k < 2; k++) begin
      ef = {br && !rst, br && !rst, br && !rst && !cfg_bie(k)};
      check($sformatf("stall[%0d]", k), 32'(o_stall[k]), 32'(exp_stall(k)));
      check($sformatf("flush[%0d]", k), 32'(o_flush[k]), 32'(ef));
      check($sformatf("sel_a[%0d]", k), 32'(o_sel_a[k]), m_sel_a[k]);
      check($sformatf("sel_b[%0d]", k), 32'(o_sel_b[k]), m_sel_b[k]);
      check($sformatf("stall_cnt[%0d]", k), o_scnt[k], m_scnt[k]);
      check($sformatf("flush_cnt[%0d]", k), o_fcnt[k], m_fcnt[k]);
      last_stall[k] = o_stall[k];
      last_flush[k] = o_flush[k];
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_update(k);
    #1;
  endtask

  task automatic rst_cycle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_reg_write = 0; id_mem_read = 0; id_rd = 0; branch_taken = 0;
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = '0; m_mem[k] = '0;
      m_sel_a[k] = 0; m_sel_b[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
    end
    repeat (2) @(posedge clk);

    // Reset state
    rst_cycle();
    check("rst_sel_a0", 32'(o_sel_a[0]), 0);
    check("rst_sel_b1", 32'(o_sel_b[1]), 0);
    check("rst_scnt0", o_scnt[0], 0);
    check("rst_fcnt1", o_fcnt[1], 0);

    // Load-use: lw r8 then add r10,r8,r0
    rst_cycle();
    step(0, 1, 0, 0, 0, 0, 1, 1, 8, 0);
    step(0, 1, 8, 1, 0, 1, 1, 0, 10, 0);
    check("lu_stall", 32'(last_stall[0]), 1);
    step(0, 1, 8, 1, 0, 1, 1, 0, 10, 0);
    check("lu_stall_once", 32'(last_stall[0]), 0);
    check("lu_sel_a", 32'(o_sel_a[0]), 2);
    check("lu_sel_b", 32'(o_sel_b[0]), 0);
    check("lu_scnt", o_scnt[0], 1);

    // ALU chain: add r3 then sub r4,r3,r3
    rst_cycle();
    step(0, 1, 0, 0, 0, 0, 1, 0, 3, 0);
    step(0, 1, 3, 1, 3, 1, 1, 0, 4, 0);
    check("alu_stall", 32'(last_stall[0]), 0);
    check("alu_sel_a", 32'(o_sel_a[0]), 1);
    check("alu_sel_b", 32'(o_sel_b[0]), 1);

    // Zero register
    rst_cycle();
    step(0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 1, 0, 1, 0, 1, 1, 0, 9, 0);
    check("zero_stall0", 32'(last_stall[0]), 0);
    check("zero_stall1", 32'(last_stall[1]), 0);
    check("zero_sel_a", 32'(o_sel_a[0]), 0);
    check("zero_sel_b", 32'(o_sel_b[0]), 0);

    // Branch taken while a load-use is pending
    rst_cycle();
    step(0, 1, 0, 0, 0, 0, 1, 1, 8, 0);
    step(0, 1, 8, 1, 0, 0, 1, 0, 10, 1);
    check("br_stall", 32'(last_stall[0]), 0);
    check("br_flush0", 32'(last_flush[0]), 7);
    check("br_flush1", 32'(last_flush[1]), 6);
    check("br_fcnt", o_fcnt[0], 1);
    check("br_scnt", o_scnt[0], 0);
    step(0, 1, 8, 1, 0, 0, 1, 0, 10, 0);
    check("br_slots_empty", 32'(last_stall[0]), 0);

    // Stall-only: back-to-back dependence, then one-gap dependence
    rst_cycle();
    step(0, 1, 0, 0, 0, 0, 1, 0, 5, 0);
    step(0, 1, 0, 0, 5, 1, 1, 0, 6, 0);
    check("nf_stall_1", 32'(last_stall[1]), 1);
    step(0, 1, 0, 0, 5, 1, 1, 0, 6, 0);
    check("nf_stall_2", 32'(last_stall[1]), 1);
    step(0, 1, 0, 0, 5, 1, 1, 0, 6, 0);
    check("nf_stall_3", 32'(last_stall[1]), 0);
    check("nf_scnt", o_scnt[1], 2);
    check("nf_sel_b", 32'(o_sel_b[1]), 0);
    rst_cycle();
    step(0, 1, 0, 0, 0, 0, 1, 0, 5, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
    check("gap_stall_1", 32'(last_stall[1]), 1);
    step(0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
    check("gap_stall_2", 32'(last_stall[1]), 0);

    // Reset asserted during the load-use stall
    rst_cycle();
    step(0, 1, 0, 0, 0, 0, 1, 1, 8, 0);
    step(0, 1, 8, 1, 0, 0, 1, 0, 10, 0);
    check("rs_stall", 32'(last_stall[0]), 1);
    step(1, 1, 8, 1, 0, 0, 1, 0, 10, 0);
    check("rs_stall_in_reset", 32'(last_stall[0]), 0);
    check("rs_sel_a", 32'(o_sel_a[0]), 0);
    check("rs_scnt", o_scnt[0], 0);
    step(0, 1, 8, 1, 0, 0, 1, 0, 10, 0);
    check("rs_no_residual", 32'(last_stall[0]), 0);

    // 2-bit counter saturation: six stalls on the stall-only unit
    rst_cycle();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0, 0, 1, 0, 5, 0);
      repeat (3) step(0, 1, 0, 0, 5, 1, 0, 0, 0, 0);
    end
    check("sat_scnt1", o_scnt[1], 3);
    check("sat_scnt0", o_scnt[0], 0);

    // Randomised traffic with small register numbers to provoke dependences
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) != 0),
           int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
           1'($urandom), ($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
